halfstrip_scan_sequencer: RTL

//  Sequences comparator_injector across a range of halfstrips. For each halfstrip it selects
//  the halfstrip, clears the error counters, fires one pulse burst and waits for completion.
//  It then captures the three error counts and hands one result record per halfstrip to the

---
 rtl/comptest_pkg.sv | 35 +++
 rtl/scan_result_reg.sv | 52 +++++
 rtl/halfstrip_scan_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/comptest_pkg.sv
// Shared definitions for the comparator-test scan logic.
//   scan_state_t  - 3-bit state encoding of the halfstrip scan sequencer
//   scan_result_t - one result record (halfstrip, three error counts, timeout flag)
//   HS_W / ERRCNT_W / WD_W - halfstrip, error-count and watchdog counter widths
package comptest_pkg;

  localparam int HS_W     = 5;
  localparam int ERRCNT_W = 16;
  localparam int WD_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETUP      = 3'd1,
    S_FIRE       = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_DRAIN      = 3'd4,
    S_CAPTURE    = 3'd5,
    S_REPORT     = 3'd6,
    S_ABORT_WAIT = 3'd7
  } scan_state_t;

  typedef struct packed {
    logic [HS_W-1:0]     hs;
    logic [ERRCNT_W-1:0] thr;
    logic [ERRCNT_W-1:0] off;
    logic [ERRCNT_W-1:0] cmp;
    logic                timeout;
  } scan_result_t;

  // Halfstrip increment; the 5-bit result wraps 31 -> 0 so reversed ranges sweep through zero.
  function automatic logic [HS_W-1:0] next_hs(input logic [HS_W-1:0] hs);
    return hs + 1'b1;
  endfunction

endpackage

// File: rtl/scan_result_reg.sv
// Result record register with valid/ready output handshake.
//   clock, reset - system clock, async active-high reset
//   i_load       - capture i_rec and raise o_valid
//   i_drop       - discard a pending record (abort); beats load and transfer
//   i_rec        - record to capture
//   i_ready      - consumer accepts the record
//   o_valid      - record available; o_rec held stable while high
//   o_rec        - registered record
//   o_xfer       - record is transferred on this clock edge
module scan_result_reg
  import comptest_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_drop,
  input  scan_result_t i_rec,
  input  logic         i_ready,
  output logic         o_valid,
  output scan_result_t o_rec,
  output logic         o_xfer
);

  logic         r_valid;
  scan_result_t r_rec;

  // A record offered in the same cycle as an abort is never transferred.
  assign o_xfer = r_valid & i_ready & ~i_drop;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  // NOTE: the record fields are reset too, so result outputs read 0 straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_rec   <= '0;
    end else begin
      if (i_drop) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
        r_rec   <= i_rec;
      end else if (o_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_rec   = r_rec;

endmodule

// File: rtl/halfstrip_scan_sequencer.sv
// Sequences the comparator injector over a halfstrip range and reports one record per halfstrip.
// For each halfstrip: select it and clear the error counters, let the mask settle, fire one
// pulse burst, wait for the pulser, drain the error pipeline, capture the three counts and
// hand the record out over valid/ready.
//   clock, reset          - system clock, async active-high reset
//   start, abort          - scan launch (rising edge in IDLE) / terminate (level)
//   hs_first, hs_last     - inclusive halfstrip range, sampled at launch
//   active_halfstrip, halfstrip_mask_en, fire_pulse, errcnt_rst - to the injector
//   pulser_ready, *_errcnt - from the injector
//   result_*              - result record and handshake
//   busy, done, aborted   - scan status
module halfstrip_scan_sequencer
  import comptest_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DRAIN_CYC  = 4,
  parameter int WATCHDOG   = 65535
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [HS_W-1:0]     hs_first,
  input  logic [HS_W-1:0]     hs_last,
  output logic [HS_W-1:0]     active_halfstrip,
  output logic                halfstrip_mask_en,
  output logic                fire_pulse,
  input  logic                pulser_ready,
  output logic                errcnt_rst,
  input  logic [ERRCNT_W-1:0] thresholds_errcnt,
  input  logic [ERRCNT_W-1:0] offsets_errcnt,
  input  logic [ERRCNT_W-1:0] compout_errcnt,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [HS_W-1:0]     result_hs,
  output logic [ERRCNT_W-1:0] result_thr,
  output logic [ERRCNT_W-1:0] result_off,
  output logic [ERRCNT_W-1:0] result_cmp,
  output logic                result_timeout,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int CNT_MAX = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(WATCHDOG - 1);

  scan_state_t      r_state;
  logic             r_start_d;
  logic [HS_W-1:0]  r_cur_hs;
  logic [HS_W-1:0]  r_last_hs;
  logic [HS_W-1:0]  r_active_hs;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wd;
  logic             r_wd_flag;
  logic             r_fire;
  logic             r_errcnt_rst;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic         w_start_edge;
  logic         w_abort;
  logic         w_wd_expired;
  logic         w_load;
  logic         w_xfer;
  scan_result_t w_cap_rec;
  scan_result_t w_out_rec;

  assign w_start_edge = start & ~r_start_d;
  // ABORT_WAIT is already the abort path; re-entering it would restart its watchdog forever.
  assign w_abort      = abort & (r_state != S_IDLE) & (r_state != S_ABORT_WAIT);
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_load       = (r_state == S_CAPTURE);

  assign w_cap_rec.hs      = r_cur_hs;
  assign w_cap_rec.thr     = thresholds_errcnt;
  assign w_cap_rec.off     = offsets_errcnt;
  assign w_cap_rec.cmp     = compout_errcnt;
  assign w_cap_rec.timeout = r_wd_flag;

  scan_result_reg u_result (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_drop  (w_abort),
    .i_rec   (w_cap_rec),
    .i_ready (result_ready),
    .o_valid (result_valid),
    .o_rec   (w_out_rec),
    .o_xfer  (w_xfer)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_start_d    <= 1'b0;
      r_cur_hs     <= '0;
      r_last_hs    <= '0;
      r_active_hs  <= '0;
      r_cnt        <= '0;
      r_wd         <= '0;
      r_wd_flag    <= 1'b0;
      r_fire       <= 1'b0;
      r_errcnt_rst <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_start_d    <= start;
      r_done       <= 1'b0;
      r_errcnt_rst <= 1'b0;

      if (w_abort) begin
        r_state   <= S_ABORT_WAIT;
        r_fire    <= 1'b0;
        r_aborted <= 1'b1;
        r_wd      <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_edge) begin
              r_state      <= S_SETUP;
              r_cur_hs     <= hs_first;
              r_active_hs  <= hs_first;
              r_last_hs    <= hs_last;
              r_aborted    <= 1'b0;
              r_busy       <= 1'b1;
              r_errcnt_rst <= 1'b1;
              r_wd_flag    <= 1'b0;
              r_cnt        <= '0;
            end
          end

          S_SETUP: begin
            if (r_cnt == SETTLE_LAST) begin
              r_state <= S_FIRE;
              r_fire  <= 1'b1;
              r_wd    <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_FIRE, S_WAIT_DONE: begin
            r_wd <= r_wd + 1'b1;
            if (w_wd_expired) begin
              r_state   <= S_DRAIN;
              r_fire    <= 1'b0;
              r_wd_flag <= 1'b1;
              r_cnt     <= '0;
            end else if (r_state == S_FIRE) begin
              // The injector drops pulser_ready once it has accepted the debounced fire.
              if (!pulser_ready) begin
                r_state <= S_WAIT_DONE;
                r_fire  <= 1'b0;
              end
            end else if (pulser_ready) begin
              r_state <= S_DRAIN;
              r_cnt   <= '0;
            end
          end

          S_DRAIN: begin
            // Lets the last errors propagate through the injector's err->count pipeline.
            if (r_cnt == DRAIN_LAST) begin
              r_state <= S_CAPTURE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_CAPTURE: begin
            r_state <= S_REPORT;
          end

          S_REPORT: begin
            if (w_xfer) begin
              if (r_cur_hs == r_last_hs) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state      <= S_SETUP;
                r_cur_hs     <= next_hs(r_cur_hs);
                r_active_hs  <= next_hs(r_cur_hs);
                r_errcnt_rst <= 1'b1;
                r_wd_flag    <= 1'b0;
                r_cnt        <= '0;
              end
            end
          end

          S_ABORT_WAIT: begin
            if (pulser_ready || w_wd_expired) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_fire  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign active_halfstrip  = r_active_hs;
  assign halfstrip_mask_en = r_busy;
  assign busy              = r_busy;
  assign fire_pulse        = r_fire;
  assign errcnt_rst        = r_errcnt_rst;
  assign done              = r_done;
  assign aborted           = r_aborted;
  assign result_hs         = w_out_rec.hs;
  assign result_thr        = w_out_rec.thr;
  assign result_off        = w_out_rec.off;
  assign result_cmp        = w_out_rec.cmp;
  assign result_timeout    = w_out_rec.timeout;

endmodule
